// File: rtl/mux_if.sv
// Bus bundle for the word-select mux: packed word array in, combinational and captured selection out.
// Define MUX_PARITY_EN to add the registered parity signal.
interface mux_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEL_W = 3
);
  logic [WIDTH*DEPTH-1:0] Q;
  logic [SEL_W-1:0]       sel;
  logic                   en;
  logic [WIDTH-1:0]       source;
  logic [DEPTH-1:0]       sel_onehot;
  logic [WIDTH-1:0]       source_q;
  logic [SEL_W-1:0]       sel_q;
  logic                   valid;
`ifdef MUX_PARITY_EN
  logic                   parity;
`endif

  modport master (
    output Q, sel, en,
    input  source, sel_onehot, source_q, sel_q, valid
`ifdef MUX_PARITY_EN
    , input parity
`endif
  );

  modport slave (
    input  Q, sel, en,
    output source, sel_onehot, source_q, sel_q, valid
`ifdef MUX_PARITY_EN
    , output parity
`endif
  );
endinterface

// File: rtl/mux.sv
// Word-select mux: combinational select/one-hot decode plus an en-strobed capture register with a valid pulse.
// Define MUX_PARITY_EN to add a registered even-XOR parity of the captured word.
module mux #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEL_W = 3
) (
  input logic   clk,
  input logic   rst_n,
  mux_if.slave  bus
);

  logic [WIDTH-1:0] source_c;
  logic [DEPTH-1:0] onehot_c;

  logic [WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             valid_q, valid_d;
`ifdef MUX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Select word sel; unselected words are masked out by the compare so they cannot leak through.
  always_comb begin
    source_c = '0;
    onehot_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (SEL_W'(i) == bus.sel) begin
        source_c    = bus.Q[i*WIDTH +: WIDTH];
        onehot_c[i] = 1'b1;
      end
    end
  end

  // Capture on en; valid is a one-cycle pulse per capture and stays high across back-to-back captures.
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
`ifdef MUX_PARITY_EN
    parity_d = parity_q;
`endif
    if (bus.en) begin
      data_d  = source_c;
      sel_d   = bus.sel;
      valid_d = 1'b1;
`ifdef MUX_PARITY_EN
      parity_d = ^source_c;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
`ifdef MUX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
`ifdef MUX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.source     = source_c;
  assign bus.sel_onehot = onehot_c;
  assign bus.source_q   = data_q;
  assign bus.sel_q      = sel_q;
  assign bus.valid      = valid_q;
`ifdef MUX_PARITY_EN
  assign bus.parity     = parity_q;
`endif

endmodule

// File: tb/tb_mux.sv
// Scoreboard bench for mux: captures push expected words, a negedge monitor pops them on valid.
// Combinational paths and reset behaviour are checked directly against hand-computed constants.
module tb_mux;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SEL_W = 3;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             par;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  mux_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) bus ();

  mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s, input logic p);
    exp_t e;
    e.data = d;
    e.sel  = s;
    e.par  = p;
    sb.push_back(e);
  endtask

  // Monitor: every valid cycle must match the oldest outstanding capture.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: valid with empty scoreboard, source_q %h at %0t", bus.source_q, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_source_q", 32'(bus.source_q), 32'(e.data));
        chk("sb_sel_q", 32'(bus.sel_q), 32'(e.sel));
`ifdef MUX_PARITY_EN
        chk("sb_parity", 32'(bus.parity), 32'(e.par));
`endif
      end
    end
  end

  logic [WIDTH*DEPTH-1:0] q;
  logic [WIDTH*DEPTH-1:0] q_dist;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    bus.Q    = '0;
    bus.sel  = '0;
    bus.en   = 1'b0;
    q_dist   = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_source_q", 32'(bus.source_q), 32'h0);
    chk("rst_sel_q", 32'(bus.sel_q), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Walking word
    for (int s = 0; s < 8; s++) begin
      q = '0;
      q[s*WIDTH +: WIDTH] = 16'hFFFF;
      bus.Q   = q;
      bus.sel = SEL_W'(s);
      #1;
      chk($sformatf("walk_source_%0d", s), 32'(bus.source), 32'hFFFF);
    end
    bus.Q   = '0;
    bus.sel = '0;
    #1;
    chk("walk_zero", 32'(bus.source), 32'h0);

    // Distinct words and one-hot decode
    bus.Q = q_dist;
    for (int s = 0; s < 8; s++) begin
      bus.sel = SEL_W'(s);
      #1;
      chk($sformatf("dist_source_%0d", s), 32'(bus.source), 32'h1111 * s);
      chk($sformatf("onehot_%0d", s), 32'(bus.sel_onehot), 32'h1 << s);
    end

    // Unselected words must not matter
    bus.sel = 3'd3;
    bus.Q   = 128'hDEAD_BEEF_0BAD_CAFE_3333_F00D_1234_ABCD;
    #1;
    chk("unsel_source", 32'(bus.source), 32'h3333);
    bus.Q = q_dist;

    // Single capture then hold
    tick();
    bus.sel = 3'd5;
    bus.en  = 1'b1;
    push(16'h5555, 3'd5, 1'b0);
    tick();
    bus.en = 1'b0;
    chk("cap_valid_hi", 32'(bus.valid), 32'h1);
    chk("cap_source_q", 32'(bus.source_q), 32'h5555);
    tick();
    chk("cap_valid_lo", 32'(bus.valid), 32'h0);
    chk("hold_source_q", 32'(bus.source_q), 32'h5555);
    chk("hold_sel_q", 32'(bus.sel_q), 32'h5);
    bus.sel = 3'd1;
    #1;
    chk("hold_follow_source", 32'(bus.source), 32'h1111);
    chk("hold_source_q2", 32'(bus.source_q), 32'h5555);

    // Back-to-back captures keep valid high
    bus.en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      bus.sel = SEL_W'(s);
      push(WIDTH'(16'h1111 * s), SEL_W'(s), 1'b0);
      tick();
      chk($sformatf("b2b_valid_%0d", s), 32'(bus.valid), 32'h1);
      chk($sformatf("b2b_source_q_%0d", s), 32'(bus.source_q), 32'h1111 * s);
    end
    bus.en = 1'b0;
    tick();
    chk("b2b_valid_end", 32'(bus.valid), 32'h0);

    // Reset mid-capture: async clear, reset beats en
    bus.sel = 3'd7;
    bus.en  = 1'b1;
    push(16'h7777, 3'd7, 1'b0);
    tick();
    #5;
    rst_n   = 1'b0;
    bus.sel = 3'd6;
    #1;
    chk("mid_rst_source_q", 32'(bus.source_q), 32'h0);
    chk("mid_rst_sel_q", 32'(bus.sel_q), 32'h0);
    chk("mid_rst_valid", 32'(bus.valid), 32'h0);
    tick();
    chk("rst_wins_source_q", 32'(bus.source_q), 32'h0);
    chk("rst_wins_valid", 32'(bus.valid), 32'h0);
    rst_n   = 1'b1;
    bus.sel = 3'd2;
    push(16'h2222, 3'd2, 1'b0);
    tick();
    bus.en = 1'b0;
    chk("post_rst_source_q", 32'(bus.source_q), 32'h2222);
    chk("post_rst_sel_q", 32'(bus.sel_q), 32'h2);

    // Parity captures
    bus.Q   = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0001;
    bus.sel = 3'd0;
    bus.en  = 1'b1;
    push(16'h0001, 3'd0, 1'b1);
    tick();
    bus.Q = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0003;
    push(16'h0003, 3'd0, 1'b0);
    tick();
    bus.en = 1'b0;
    bus.Q  = 128'h0;
    tick();
`ifdef MUX_PARITY_EN
    chk("parity_hold", 32'(bus.parity), 32'h0);
`endif
    chk("par_hold_source_q", 32'(bus.source_q), 32'h0003);

    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
- REQ-001: Parameter WIDTH, default 16, SHALL set the bit width of one data word.
- REQ-002: Parameter DEPTH, default 8, SHALL set the number of words; it SHALL be a power of two, at least 2.
- REQ-003: Parameter SEL_W, default 3, SHALL set the select width; it SHALL equal log2(DEPTH).
- REQ-004: clk, input, 1: the single clock; all registers SHALL update on its rising edge.
- REQ-005: rst_n, input, 1: asynchronous, active-low reset.
- REQ-006: Q, input, WIDTH*DEPTH: packed word array; word i SHALL occupy bits [i*WIDTH+WIDTH-1 : i*WIDTH], so word 0 is at the LSBs.
- REQ-007: sel, input, SEL_W: index of the selected word.
- REQ-008: en, input, 1: capture strobe for the registered path.
- REQ-009: source, output, WIDTH: combinational selected word.
- REQ-010: sel_onehot, output, DEPTH: combinational one-hot decode of sel.
- REQ-011: source_q, output, WIDTH: registered selected word.
- REQ-012: sel_q, output, SEL_W: registered select captured together with source_q.
- REQ-013: valid, output, 1: asserted high for exactly one cycle after each capture.

Function
- REQ-014: source SHALL equal word sel of Q with zero latency, and SHALL follow any change of Q or sel in the same delta cycle.
- REQ-015: sel_onehot SHALL have exactly bit sel set and all other bits clear, combinationally.
- REQ-016: On a rising clk edge with en=1, source_q SHALL load word sel of Q, sel_q SHALL load sel, and valid SHALL go to 1.
- REQ-017: On a rising clk edge with en=0, source_q and sel_q SHALL hold their values and valid SHALL go to 0.
- REQ-018: Back-to-back en=1 cycles SHALL capture a new word on every edge, and valid SHALL stay high continuously.
- REQ-019: Every sel value 0..DEPTH-1 is legal; no out-of-range case exists, and no index wrap logic is required.
- REQ-020: Only the selected word SHALL affect the outputs; the contents of unselected words SHALL have no effect.
- REQ-021: source and sel_onehot SHALL be independent of clk, en and rst_n.

Reset
- REQ-022: While rst_n=0, source_q, sel_q and valid SHALL be 0, and if enabled parity SHALL also be 0; reset SHALL take effect immediately, without waiting for a clock edge.
- REQ-023: If reset is asserted in a cycle where en=1, the reset SHALL win and no capture SHALL occur.
- REQ-024: The first capture after release SHALL occur on the first rising edge with rst_n=1 and en=1.

Configuration
- REQ-025: When macro MUX_PARITY_EN is defined, the block SHALL add an output parity, 1 bit wide, registered alongside source_q and equal to the XOR of all bits of the captured word; it SHALL hold its value when en=0.
- REQ-026: When MUX_PARITY_EN is not defined, the parity port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
- REQ-027: Walking word: for sel = 0..7, drive Q with word sel = FFFF and all other words = 0000 -> source = FFFF each step; with Q = 0 and sel = 0 -> source = 0000.
- REQ-028: Distinct words: word i = 16'h1111*i, sweep sel 0..7 -> source = 16'h1111*sel, and sel_onehot = 8'h01 << sel.
- REQ-029: Capture: sel=5 with en=1 for one edge, then en=0 -> source_q = 5555 and sel_q = 5, valid high for one cycle only, and source_q holds while source follows new sel values.
- REQ-030: Reset: hold rst_n low mid-capture -> source_q, sel_q and valid are 0 immediately; release, then en=1 with sel=2 -> source_q = 2222 on the next edge.
- REQ-031: Parity (MUX_PARITY_EN defined): capture 0001 -> parity = 1; capture 0003 -> parity = 0; with the macro undefined the build contains no parity port.
